// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
package mem_arb_pkg;

    // Default data width, address width and access timeout.
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_TIMEOUT    = 255;

    // Width of the ACCESS cycle counter; it must hold TIMEOUT-1 for any legal TIMEOUT.
    localparam int CNT_WIDTH = 16;

    // Arbiter control states: waiting, memory command in flight, completion pulse.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_e;

    // Last count value reached before the access is abandoned.
    function automatic logic [CNT_WIDTH-1:0] timeoutLimit(input int timeout);
        return CNT_WIDTH'(timeout - 1);
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone request always wins, and under contention
// the requester that was not granted last takes the slot.
module mem_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant is one-hot when anything is requested, zero otherwise.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single memory port, one access at a time,
// with a per-access timeout that completes the request with an error flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    input  logic                  r0_wr_en,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0]      r0_wdata,
    output logic                  r0_ready,
    output logic [WIDTH-1:0]      r0_rdata,
    output logic                  r0_err,

    input  logic                  r1_valid,
    input  logic                  r1_wr_en,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0]      r1_wdata,
    output logic                  r1_ready,
    output logic [WIDTH-1:0]      r1_rdata,
    output logic                  r1_err,

    output logic                  m_valid,
    output logic                  m_wr_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_rdata,
    input  logic                  m_ready,

    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] COUNT_LIMIT = timeoutLimit(TIMEOUT);

    arbState_e             state_q,    state_d;
    logic                  grant_q,    grant_d;
    logic                  last_q,     last_d;
    logic                  cmdWr_q,    cmdWr_d;
    logic [ADDR_WIDTH-1:0] cmdAddr_q,  cmdAddr_d;
    logic [WIDTH-1:0]      cmdWdata_q, cmdWdata_d;
    logic [CNT_WIDTH-1:0]  count_q,    count_d;
    logic                  err_q,      err_d;
    logic [WIDTH-1:0]      rdata0_q,   rdata0_d;
    logic [WIDTH-1:0]      rdata1_q,   rdata1_d;

    logic [1:0]            rrGnt;

    mem_arb_rr uRr (
        .req  ({r1_valid, r0_valid}),
        .last (last_q),
        .gnt  (rrGnt)
    );

    // Next-state logic: grant and latch the command in IDLE, wait for the
    // memory or the timeout in ACCESS, then hand back a single completion in DONE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cmdWr_d    = cmdWr_q;
        cmdAddr_d  = cmdAddr_q;
        cmdWdata_d = cmdWdata_q;
        count_d    = count_q;
        err_d      = err_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            IDLE: begin
                if (rrGnt != 2'b00) begin
                    grant_d    = rrGnt[1];
                    cmdWr_d    = rrGnt[1] ? r1_wr_en : r0_wr_en;
                    cmdAddr_d  = rrGnt[1] ? r1_addr  : r0_addr;
                    cmdWdata_d = rrGnt[1] ? r1_wdata : r0_wdata;
                    count_d    = '0;
                    err_d      = 1'b0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (m_ready) begin
                    if (!cmdWr_q) begin
                        if (grant_q) begin
                            rdata1_d = m_rdata;
                        end else begin
                            rdata0_d = m_rdata;
                        end
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (count_q == COUNT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and biases the
    // first contention toward requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            cmdWr_q    <= 1'b0;
            cmdAddr_q  <= '0;
            cmdWdata_q <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cmdWr_q    <= cmdWr_d;
            cmdAddr_q  <= cmdAddr_d;
            cmdWdata_q <= cmdWdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Outputs decoded from registered state so they follow reset immediately.
    always_comb begin
        m_valid  = (state_q == ACCESS);
        m_wr_en  = cmdWr_q;
        m_addr   = cmdAddr_q;
        m_wdata  = cmdWdata_q;
        busy     = (state_q != IDLE);
        r0_ready = (state_q == DONE) && !grant_q;
        r1_ready = (state_q == DONE) &&  grant_q;
        r0_err   = r0_ready && err_q;
        r1_err   = r1_ready && err_q;
        r0_rdata = rdata0_q;
        r1_rdata = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: write path, contention, round-robin fairness,
// timeout completion and reset during an access.
module tb_mem_arbiter;

    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 6;
    localparam int TIMEOUT    = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  r0_valid, r0_wr_en, r0_ready, r0_err;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [WIDTH-1:0]      r0_wdata, r0_rdata;
    logic                  r1_valid, r1_wr_en, r1_ready, r1_err;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [WIDTH-1:0]      r1_wdata, r1_rdata;
    logic                  m_valid, m_wr_en, m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [WIDTH-1:0]      m_wdata, m_rdata;
    logic                  busy;

    logic                  memEnable;
    logic [WIDTH-1:0]      memData;

    int passCount  = 0;
    int checkCount = 0;

    mem_arbiter #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0_valid (r0_valid),
        .r0_wr_en (r0_wr_en),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_ready (r0_ready),
        .r0_rdata (r0_rdata),
        .r0_err   (r0_err),
        .r1_valid (r1_valid),
        .r1_wr_en (r1_wr_en),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_ready (r1_ready),
        .r1_rdata (r1_rdata),
        .r1_err   (r1_err),
        .m_valid  (m_valid),
        .m_wr_en  (m_wr_en),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    // Memory model answers in the first ACCESS cycle whenever enabled.
    assign m_ready = memEnable && m_valid;
    assign m_rdata = memData;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both readies together is never legal, checked every cycle.
    always @(negedge clk) begin
        checkCount++;
        if (r0_ready && r1_ready) $display("[TB] FAIL both_ready got r0=%0b r1=%0b exp not both", r0_ready, r1_ready);
        else passCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid got %0b exp 0", m_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b exp 0", busy); else passCount++;
        checkCount++; if (m_addr !== 6'd0 || m_wdata !== 16'h0 || m_wr_en !== 1'b0) $display("[TB] FAIL reset_cmd got addr=%0h wdata=%0h wr=%0b exp 0", m_addr, m_wdata, m_wr_en); else passCount++;
        checkCount++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || r0_err !== 1'b0 || r1_err !== 1'b0) $display("[TB] FAIL reset_ready got %0b%0b%0b%0b exp 0000", r0_ready, r1_ready, r0_err, r1_err); else passCount++;
        checkCount++; if (r0_rdata !== 16'h0 || r1_rdata !== 16'h0) $display("[TB] FAIL reset_rdata got %0h/%0h exp 0/0", r0_rdata, r1_rdata); else passCount++;
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        r0_valid = 1'b1; r0_wr_en = 1'b1; r0_addr = 6'd5; r0_wdata = 16'hA5A5;
        memEnable = 1'b1;
        tick();
        checkCount++; if (m_valid !== 1'b1) $display("[TB] FAIL wr_m_valid got %0b exp 1", m_valid); else passCount++;
        checkCount++; if (m_addr !== 6'd5) $display("[TB] FAIL wr_m_addr got %0h exp 5", m_addr); else passCount++;
        checkCount++; if (m_wdata !== 16'hA5A5) $display("[TB] FAIL wr_m_wdata got %0h exp a5a5", m_wdata); else passCount++;
        checkCount++; if (m_wr_en !== 1'b1) $display("[TB] FAIL wr_m_wr_en got %0b exp 1", m_wr_en); else passCount++;
        checkCount++; if (busy !== 1'b1 || r0_ready !== 1'b0) $display("[TB] FAIL wr_access got busy=%0b ready=%0b exp 1/0", busy, r0_ready); else passCount++;
        tick();
        checkCount++; if (r0_ready !== 1'b1 || r0_err !== 1'b0) $display("[TB] FAIL wr_done got ready=%0b err=%0b exp 1/0", r0_ready, r0_err); else passCount++;
        checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL wr_done_m_valid got %0b exp 0", m_valid); else passCount++;
        tick();
        r0_valid = 1'b0;
        checkCount++; if (r0_ready !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL wr_idle got ready=%0b busy=%0b exp 0/0", r0_ready, busy); else passCount++;
        checkCount++; if (r0_rdata !== 16'h0) $display("[TB] FAIL wr_rdata_kept got %0h exp 0", r0_rdata); else passCount++;
        tick();
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        r0_valid = 1'b1; r0_wr_en = 1'b0; r0_addr = 6'd1; r0_wdata = 16'h0;
        r1_valid = 1'b1; r1_wr_en = 1'b0; r1_addr = 6'd2; r1_wdata = 16'h0;
        memEnable = 1'b1; memData = 16'h1111;
        tick();
        checkCount++; if (m_addr !== 6'd1 || m_wr_en !== 1'b0) $display("[TB] FAIL cont_first_addr got %0h wr=%0b exp 1/0", m_addr, m_wr_en); else passCount++;
        tick();
        checkCount++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) $display("[TB] FAIL cont_first_ready got r0=%0b r1=%0b exp 1/0", r0_ready, r1_ready); else passCount++;
        checkCount++; if (r0_rdata !== 16'h1111) $display("[TB] FAIL cont_r0_rdata got %0h exp 1111", r0_rdata); else passCount++;
        memData = 16'h2222;
        tick();
        r0_valid = 1'b0;
        tick();
        checkCount++; if (m_addr !== 6'd2 || m_valid !== 1'b1) $display("[TB] FAIL cont_second_addr got %0h valid=%0b exp 2/1", m_addr, m_valid); else passCount++;
        tick();
        checkCount++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) $display("[TB] FAIL cont_second_ready got r0=%0b r1=%0b exp 0/1", r0_ready, r1_ready); else passCount++;
        checkCount++; if (r1_rdata !== 16'h2222 || r0_rdata !== 16'h1111) $display("[TB] FAIL cont_rdata got %0h/%0h exp 1111/2222", r0_rdata, r1_rdata); else passCount++;
        tick();
        r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int grants0 = 0;
        int grants1 = 0;
        r0_valid = 1'b1; r0_wr_en = 1'b1; r0_addr = 6'd10; r0_wdata = 16'h0A0A;
        r1_valid = 1'b1; r1_wr_en = 1'b1; r1_addr = 6'd20; r1_wdata = 16'h1414;
        memEnable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int waited = 0;
            while (!(r0_ready || r1_ready) && waited < 10) begin
                tick();
                waited++;
            end
            checkCount++; if (waited >= 10) $display("[TB] FAIL rr_timeout_%0d got no ready exp ready within 10", i); else passCount++;
            checkCount++; if (r0_ready !== (i % 2 == 0)) $display("[TB] FAIL rr_order_%0d got r0_ready=%0b exp %0b", i, r0_ready, (i % 2 == 0)); else passCount++;
            if (r0_ready) grants0++;
            if (r1_ready) grants1++;
            tick();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        checkCount++; if (grants0 != 4 || grants1 != 4) $display("[TB] FAIL rr_share got %0d/%0d exp 4/4", grants0, grants1); else passCount++;
    endtask

    task automatic test_timeout();
        int accessCycles = 0;
        memEnable = 1'b0; memData = 16'hFFFF;
        r1_valid = 1'b1; r1_wr_en = 1'b0; r1_addr = 6'd7;
        tick();
        while (m_valid && accessCycles < 20) begin
            accessCycles++;
            tick();
        end
        checkCount++; if (accessCycles != 4) $display("[TB] FAIL to_cycles got %0d exp 4", accessCycles); else passCount++;
        checkCount++; if (r1_ready !== 1'b1 || r1_err !== 1'b1) $display("[TB] FAIL to_done got ready=%0b err=%0b exp 1/1", r1_ready, r1_err); else passCount++;
        checkCount++; if (r1_rdata !== 16'h2222) $display("[TB] FAIL to_rdata got %0h exp 2222", r1_rdata); else passCount++;
        checkCount++; if (r0_ready !== 1'b0 || r0_err !== 1'b0) $display("[TB] FAIL to_r0_quiet got %0b/%0b exp 0/0", r0_ready, r0_err); else passCount++;
        tick();
        r1_valid = 1'b0;
        checkCount++; if (r1_err !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL to_idle got err=%0b busy=%0b exp 0/0", r1_err, busy); else passCount++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        memEnable = 1'b1;
        r0_valid = 1'b1; r0_wr_en = 1'b1; r0_addr = 6'd3; r0_wdata = 16'h3333;
        tick();
        tick();
        tick();
        r0_valid = 1'b0;
        memEnable = 1'b0;
        r1_valid = 1'b1; r1_wr_en = 1'b0; r1_addr = 6'd9;
        tick();
        checkCount++; if (m_valid !== 1'b1 || m_addr !== 6'd9) $display("[TB] FAIL rst_pre_access got valid=%0b addr=%0h exp 1/9", m_valid, m_addr); else passCount++;
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rst_async got valid=%0b busy=%0b exp 0/0", m_valid, busy); else passCount++;
        tick();
        checkCount++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) $display("[TB] FAIL rst_no_ready got %0b/%0b exp 0/0", r0_ready, r1_ready); else passCount++;
        #2;
        rst_n = 1'b1;
        r0_valid = 1'b1; r0_wr_en = 1'b0; r0_addr = 6'd11;
        memEnable = 1'b1; memData = 16'h5A5A;
        tick();
        checkCount++; if (m_valid !== 1'b1 || m_addr !== 6'd11) $display("[TB] FAIL rst_r0_wins got valid=%0b addr=%0h exp 1/b", m_valid, m_addr); else passCount++;
        tick();
        checkCount++; if (r0_ready !== 1'b1 || r0_rdata !== 16'h5A5A) $display("[TB] FAIL rst_r0_done got ready=%0b rdata=%0h exp 1/5a5a", r0_ready, r0_rdata); else passCount++;
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
    endtask

    initial begin
        r0_valid = 1'b0; r0_wr_en = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_wr_en = 1'b0; r1_addr = '0; r1_wdata = '0;
        memEnable = 1'b0; memData = '0;
        test_reset();
        test_write();
        test_contention();
        test_round_robin();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
